// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if
// Bundles the request/response signals of the multiply sequencer with the
// operand/control/result signals of the shared execute-stage ALU.
//   slave  : the sequencer (takes requests and ALU results, drives ALU inputs
//            and the product/status outputs)
//   master : the surroundings (requester plus the ALU itself)
// Signals:
//   start, op_a, op_b         request: one-cycle start with signed operands
//   busy, done                status: busy while sequencing, done pulse
//   product, prod_z, prod_n   low WIDTH bits of the product and its flags
//   alu_a, alu_b              ALU operands driven by the sequencer
//   alu_add/inc/neg/sub       ALU op controls driven by the sequencer
//   alu_out, alu_z, alu_n     combinational ALU result and flags
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             prod_z;
  logic             prod_n;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_add;
  logic             alu_inc;
  logic             alu_neg;
  logic             alu_sub;
  logic [WIDTH-1:0] alu_out;
  logic             alu_z;
  logic             alu_n;

  modport slave (
    input  start, op_a, op_b, alu_out, alu_z, alu_n,
    output busy, done, product, prod_z, prod_n,
           alu_a, alu_b, alu_add, alu_inc, alu_neg, alu_sub
  );

  modport master (
    output start, op_a, op_b, alu_out, alu_z, alu_n,
    input  busy, done, product, prod_z, prod_n,
           alu_a, alu_b, alu_add, alu_inc, alu_neg, alu_sub
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Multi-cycle signed WIDTHxWIDTH multiplier that borrows the shared execute
// ALU instead of owning an adder. Operands are made non-negative (ABS_A,
// ABS_B), multiplied by 32 shift-and-add steps (LOOP), and the sign is
// re-applied (FIX). Every step is one ALU op; latency is fixed at 36 cycles
// from the accepting edge to the done cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_mul_sequencer_if.slave (request, ALU drive/return, result)
// ALU outputs are registered: they are computed from the next state and the
// next operand register values so that during each state the ALU already
// sees the operation belonging to that state.
module alu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_mul_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS_A = 3'd1,
    S_ABS_B = 3'd2,
    S_LOOP  = 3'd3,
    S_FIX   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             prod_z_q, prod_z_d;
  logic             prod_n_q, prod_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_add_q, alu_add_d;
  logic             alu_neg_q, alu_neg_d;

  // Next-state, datapath register updates and the ALU op for the next state
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    prod_z_d  = prod_z_q;
    prod_n_d  = prod_n_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          sign_d   = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
          acc_d    = ZERO_W;
          state_d  = S_ABS_A;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ABS_A: begin
        mcand_d = bus.alu_out;
        state_d = S_ABS_B;
      end
      S_ABS_B: begin
        mplier_d = bus.alu_out;
        acc_d    = ZERO_W;
        cnt_d    = {CNT_W{1'b0}};
        state_d  = S_LOOP;
      end
      S_LOOP: begin
        acc_d    = bus.alu_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_LOOP;
        end
      end
      S_FIX: begin
        product_d = bus.alu_out;
        prod_z_d  = bus.alu_z;
        prod_n_d  = bus.alu_n;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ALU op that will be presented while sitting in state_d.
    // A magnitude of -2^31 negates to itself and is then used as unsigned.
    alu_a_d   = ZERO_W;
    alu_b_d   = ZERO_W;
    alu_add_d = 1'b0;
    alu_neg_d = 1'b0;
    case (state_d)
      S_ABS_A: begin
        alu_a_d = mcand_d;
        if (mcand_d[WIDTH-1]) begin
          alu_neg_d = 1'b1;
        end else begin
          alu_add_d = 1'b1;
        end
      end
      S_ABS_B: begin
        alu_a_d = mplier_d;
        if (mplier_d[WIDTH-1]) begin
          alu_neg_d = 1'b1;
        end else begin
          alu_add_d = 1'b1;
        end
      end
      S_LOOP: begin
        alu_a_d   = acc_d;
        alu_b_d   = mplier_d[0] ? mcand_d : ZERO_W;
        alu_add_d = 1'b1;
      end
      S_FIX: begin
        alu_a_d = acc_d;
        if (sign_d) begin
          alu_neg_d = 1'b1;
        end else begin
          alu_add_d = 1'b1;
        end
      end
      default: begin
        alu_a_d   = ZERO_W;
        alu_b_d   = ZERO_W;
        alu_add_d = 1'b0;
        alu_neg_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= ZERO_W;
      mplier_q  <= ZERO_W;
      acc_q     <= ZERO_W;
      cnt_q     <= {CNT_W{1'b0}};
      sign_q    <= 1'b0;
      product_q <= ZERO_W;
      prod_z_q  <= 1'b0;
      prod_n_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_a_q   <= ZERO_W;
      alu_b_q   <= ZERO_W;
      alu_add_q <= 1'b0;
      alu_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      prod_z_q  <= prod_z_d;
      prod_n_q  <= prod_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_add_q <= alu_add_d;
      alu_neg_q <= alu_neg_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.prod_z  = prod_z_q;
  assign bus.prod_n  = prod_n_q;
  assign bus.alu_a   = alu_a_q;
  assign bus.alu_b   = alu_b_q;
  assign bus.alu_add = alu_add_q;
  assign bus.alu_neg = alu_neg_q;
  // INC and SUB are never needed by the shift-and-add sequence.
  assign bus.alu_inc = 1'b0;
  assign bus.alu_sub = 1'b0;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle signed 32x32 multiplier built on the shared 32-bit ALU in the execute stage; adds no adder of its own.
- Sequences ALU ADD and NEG operations as shift-and-add: one ALU operation per cycle, fixed latency.
- Drives the ALU operand and control inputs while busy; the execute-stage mux hands the ALU to this block whenever busy=1.
- Returns the low 32 bits of the product plus Z/N flags taken from the ALU.

Parameters:
- WIDTH, 32, operand/product width; must equal ALU width; only 32 supported.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- op_a  input  WIDTH  signed multiplicand; sampled with start
- op_b  input  WIDTH  signed multiplier; sampled with start
- alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/controls)
- alu_z  input  1  ALU zero flag
- alu_n  input  1  ALU negative flag
- alu_a  output  WIDTH  ALU A operand
- alu_b  output  WIDTH  ALU B operand
- alu_add  output  1  ALU add control
- alu_inc  output  1  ALU inc control; always 0
- alu_neg  output  1  ALU neg control
- alu_sub  output  1  ALU sub control; always 0
- busy  output  1  high from first cycle after accepted start through the DONE cycle
- done  output  1  one-cycle pulse; result valid
- product  output  WIDTH  low WIDTH bits of op_a*op_b; held until next accepted start
- prod_z  output  1  product==0; held with product
- prod_n  output  1  product[31]; held with product

Behaviour:
- ALU op encodings: ADD = add=1, others 0 -> out = A+B. NEG = neg=1, others 0 -> out = -A (two's complement). IDLE op = all controls 0, alu_a=alu_b=0.
- Every non-IDLE state drives exactly one combinational ALU op and registers alu_out (and alu_z/alu_n where stated) at the end of that cycle.
- Reset (rst_n=0 at a clk edge): state=IDLE; busy, done, product, prod_z, prod_n, all alu_* outputs and internal registers = 0. Reset mid-operation aborts; no done pulse.
- IDLE: IDLE op. When start=1, latch op_a into mcand and op_b into mplier, set sign = op_a[31]^op_b[31], go to ABS_A.
- ABS_A: if mcand[31], NEG with A=mcand; else ADD with A=mcand, B=0. mcand <= alu_out.
- ABS_B: same as ABS_A, applied to mplier.
- LOOP (cnt 0..31, cleared on entering LOOP): ADD with A=acc, B = mplier[0] ? mcand : 0. acc <= alu_out; mcand <= mcand<<1; mplier <= mplier>>1 (logical); cnt++. Leave for FIX after cnt=31. acc starts at 0.
- FIX: if sign, NEG with A=acc; else ADD with A=acc, B=0. product <= alu_out; prod_z <= alu_z; prod_n <= alu_n. Go to DONE.
- DONE: IDLE op; done=1 for this single cycle; busy=1; go to IDLE.
- Latency: start sampled at edge E0 -> done high during the 36th cycle after E0 (ABS_A, ABS_B, 32xLOOP, FIX, DONE). Fixed; no early termination.
- start while busy (including the DONE cycle) is ignored. Back-to-back: start in the first IDLE cycle after DONE is accepted.
- Arithmetic is modulo 2^32. Overflow is not reported. -2^31 negates to itself; the magnitude is treated as unsigned 2^31, so the low product bits stay correct.

Test Plan:
- Reset then op_a=6, op_b=7, start -> done exactly 36 cycles later; product=42, prod_z=0, prod_n=0; busy falls the cycle after done.
- op_a=-3, op_b=5 -> product=0xFFFFFFF1, prod_n=1, prod_z=0; alu_neg seen in ABS_A and FIX, alu_inc/alu_sub never 1.
- op_a=0, op_b=0x12345678 -> product=0, prod_z=1; op_a=0x00010000, op_b=0x00010000 -> product=0 (wrap), prod_z=1.
- op_a=0x80000000, op_b=-1 -> product=0x80000000, prod_n=1; op_a=-4, op_b=-4 -> product=16, prod_n=0.
- Second start pulsed at cycle 10 of an operation -> ignored, first result unchanged; start in the cycle after DONE -> accepted, new result after 36 cycles.
- rst_n=0 at cycle 20 of an operation -> next cycle busy=0, done=0, product=0, all alu_* outputs 0; a fresh start then completes normally.
